mem_port_ctrl: RTL and testbench

Per-processor front end for the shared scratchpad. It accepts one load/store command at a time from a SIMD processor and drives that processor's slice of the shared memory's request/grant and address/data ports. It holds each request until the arbiter grants it, then captures read data and returns a single response pulse. One instance sits between each processor and the shared memory, so `PORT_COUNT` instances feed the arbiter inputs.

---
 rtl/mem_port_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_port_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl.sv
// Per-processor front end for the shared scratchpad: holds one load/store
// request until the arbiter grants it, captures read data and returns one response pulse.
module mem_port_ctrl #(
  parameter int BUS_SIZE   = 160,
  parameter int ADDR_SIZE  = 24,
  parameter int RD_LATENCY = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  input  logic                 i_cmd_we,
  input  logic [ADDR_SIZE-1:0] i_cmd_addr,
  input  logic [BUS_SIZE-1:0]  i_cmd_wdata,
  input  logic [2:0]           i_cmd_size,
  output logic                 o_cmd_ready,
  output logic                 o_rsp_valid,
  output logic                 o_rsp_we,
  output logic                 o_rsp_err,
  output logic [BUS_SIZE-1:0]  o_rsp_rdata,
  output logic                 o_req_rd,
  output logic                 o_req_wr,
  input  logic                 i_grant_rd,
  input  logic                 i_grant_wr,
  output logic [ADDR_SIZE-1:0] o_addr,
  output logic [BUS_SIZE-1:0]  o_wdata,
  output logic [2:0]           o_wr_size,
  input  logic [BUS_SIZE-1:0]  i_mem_rd
);

  localparam int WAIT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT == 0) ? '0 : WAIT_W'(TIMEOUT - 1);
  localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY);

  typedef enum logic [1:0] {IDLE, REQ, RD_WAIT, RESP} state_t;

  state_t               state_q;
  logic [WAIT_W-1:0]    wait_q;
  logic [1:0]           lat_q;
  logic                 we_q;
  logic                 ready_q;
  logic                 rsp_valid_q;
  logic                 rsp_we_q;
  logic                 rsp_err_q;
  logic [BUS_SIZE-1:0]  rdata_q;
  logic                 req_rd_q;
  logic                 req_wr_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [BUS_SIZE-1:0]  wdata_q;
  logic [2:0]           size_q;

  logic grant_hit;
  logic wait_hit;

  assign grant_hit = we_q ? i_grant_wr : i_grant_rd;
  // True in the REQ cycle whose closing edge makes the wait counter reach TIMEOUT.
  assign wait_hit  = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

  // NOTE: every register below uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      lat_q       <= '0;
      we_q        <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
      req_rd_q    <= 1'b0;
      req_wr_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (i_cmd_valid && ready_q) begin
            ready_q  <= 1'b0;
            addr_q   <= i_cmd_addr;
            wdata_q  <= i_cmd_wdata;
            size_q   <= i_cmd_size;
            we_q     <= i_cmd_we;
            req_wr_q <= i_cmd_we;
            req_rd_q <= !i_cmd_we;
            wait_q   <= '0;
            state_q  <= REQ;
          end
        end
        REQ: begin
          wait_q <= (wait_q == '1) ? wait_q : wait_q + 1'b1;
          // A grant in the timeout cycle takes priority over the timeout.
          if (grant_hit) begin
            req_rd_q <= 1'b0;
            req_wr_q <= 1'b0;
            if (we_q || RD_LATENCY == 0) begin
              if (!we_q) rdata_q <= i_mem_rd;
              rsp_valid_q <= 1'b1;
              rsp_we_q    <= we_q;
              rsp_err_q   <= 1'b0;
              state_q     <= RESP;
            end else begin
              lat_q   <= LAT_INIT;
              state_q <= RD_WAIT;
            end
          end else if (wait_hit) begin
            req_rd_q    <= 1'b0;
            req_wr_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= we_q;
            rsp_err_q   <= 1'b1;
            state_q     <= RESP;
          end
        end
        RD_WAIT: begin
          if (lat_q == 2'd1) begin
            rdata_q     <= i_mem_rd;
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            state_q     <= RESP;
          end else begin
            lat_q <= lat_q - 2'd1;
          end
        end
        RESP: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready = ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_we    = rsp_we_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_rsp_rdata = rdata_q;
  assign o_req_rd    = req_rd_q;
  assign o_req_wr    = req_wr_q;
  assign o_addr      = addr_q;
  assign o_wdata     = wdata_q;
  assign o_wr_size   = size_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: four instances (RD_LATENCY 0..3, TIMEOUT 4), checked
// cycle by cycle against a transaction-level model of grant, latency and timeout rules.
module tb_mem_port_ctrl;

  localparam int BUS = 160;
  localparam int AW  = 24;
  localparam int TO  = 4;
  localparam int N   = 4;

  typedef logic [BUS-1:0] bus_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid [N];
  logic          cmd_we    [N];
  logic [AW-1:0] cmd_addr  [N];
  bus_t          cmd_wdata [N];
  logic [2:0]    cmd_size  [N];
  logic          cmd_ready [N];
  logic          rsp_valid [N];
  logic          rsp_we    [N];
  logic          rsp_err   [N];
  bus_t          rsp_rdata [N];
  logic          req_rd    [N];
  logic          req_wr    [N];
  logic          grant_rd  [N];
  logic          grant_wr  [N];
  logic [AW-1:0] addr      [N];
  bus_t          wdata     [N];
  logic [2:0]    wr_size   [N];
  bus_t          mem_rd    [N];

  int total = 0;
  int bad   = 0;

  // Stimulus schedule for one transaction, indexed by cycle number (cycle 1 follows the accept edge).
  logic [31:0] sched_rd;
  logic [31:0] sched_wr;
  bus_t        mem_seq [32];
  bus_t        exp_rdata [N];

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_dut
    mem_port_ctrl #(
      .BUS_SIZE(BUS), .ADDR_SIZE(AW), .RD_LATENCY(i), .TIMEOUT(TO)
    ) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_cmd_valid(cmd_valid[i]), .i_cmd_we(cmd_we[i]), .i_cmd_addr(cmd_addr[i]),
      .i_cmd_wdata(cmd_wdata[i]), .i_cmd_size(cmd_size[i]), .o_cmd_ready(cmd_ready[i]),
      .o_rsp_valid(rsp_valid[i]), .o_rsp_we(rsp_we[i]), .o_rsp_err(rsp_err[i]),
      .o_rsp_rdata(rsp_rdata[i]), .o_req_rd(req_rd[i]), .o_req_wr(req_wr[i]),
      .i_grant_rd(grant_rd[i]), .i_grant_wr(grant_wr[i]), .o_addr(addr[i]),
      .o_wdata(wdata[i]), .o_wr_size(wr_size[i]), .i_mem_rd(mem_rd[i])
    );
  end

  function automatic bus_t rand_bus();
    bus_t v;
    for (int w = 0; w < BUS / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic void fill_mem_seq();
    for (int k = 0; k < 32; k++) mem_seq[k] = rand_bus();
  endfunction

  // One command on instance sel. The model finds the first matching grant within
  // TIMEOUT request cycles and derives request span, response cycle and data from it.
  task automatic run_txn(input int sel, input logic we, input logic [AW-1:0] a,
                         input bus_t wd, input logic [2:0] sz, input string name);
    int   g;
    int   last_req;
    int   resp;
    logic exp_err;
    bus_t exp_data;
    logic exp_req;
    g = 0;
    for (int k = 1; k <= TO; k++)
      if (g == 0 && (we ? sched_wr[k] : sched_rd[k])) g = k;
    if (g == 0) begin
      exp_err  = 1'b1;
      last_req = TO;
      resp     = TO + 1;
      exp_data = exp_rdata[sel];
    end else begin
      exp_err  = 1'b0;
      last_req = g;
      resp     = we ? g + 1 : g + sel + 1;
      exp_data = we ? exp_rdata[sel] : mem_seq[g + sel];
    end

    total++;
    if (cmd_ready[sel] !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before got=%b exp=1", name, cmd_ready[sel]);
    end
    cmd_valid[sel] = 1'b1;
    cmd_we[sel]    = we;
    cmd_addr[sel]  = a;
    cmd_wdata[sel] = wd;
    cmd_size[sel]  = sz;
    @(posedge clk);
    for (int k = 1; k <= resp + 1; k++) begin
      @(negedge clk);
      cmd_valid[sel] = 1'b0;
      cmd_wdata[sel] = rand_bus();
      cmd_addr[sel]  = AW'($urandom);
      grant_rd[sel]  = sched_rd[k];
      grant_wr[sel]  = sched_wr[k];
      mem_rd[sel]    = mem_seq[k];
      exp_req = (k <= last_req);
      total += 4;
      if (req_wr[sel] !== (exp_req && we)) begin
        bad++;
        $display("FAIL %s c%0d req_wr got=%b exp=%b", name, k, req_wr[sel], exp_req && we);
      end
      if (req_rd[sel] !== (exp_req && !we)) begin
        bad++;
        $display("FAIL %s c%0d req_rd got=%b exp=%b", name, k, req_rd[sel], exp_req && !we);
      end
      if (rsp_valid[sel] !== (k == resp)) begin
        bad++;
        $display("FAIL %s c%0d rsp_valid got=%b exp=%b", name, k, rsp_valid[sel], k == resp);
      end
      if (cmd_ready[sel] !== (k == resp + 1)) begin
        bad++;
        $display("FAIL %s c%0d cmd_ready got=%b exp=%b", name, k, cmd_ready[sel], k == resp + 1);
      end
      if (k <= last_req) begin
        total++;
        if (addr[sel] !== a || wdata[sel] !== wd || wr_size[sel] !== sz) begin
          bad++;
          $display("FAIL %s c%0d mem_port got=%h/%0d exp=%h/%0d", name, k, addr[sel], wr_size[sel], a, sz);
        end
      end
      if (k == resp) begin
        total += 2;
        if (rsp_we[sel] !== we || rsp_err[sel] !== exp_err) begin
          bad++;
          $display("FAIL %s rsp_we/err got=%b/%b exp=%b/%b", name, rsp_we[sel], rsp_err[sel], we, exp_err);
        end
        if (rsp_rdata[sel] !== exp_data) begin
          bad++;
          $display("FAIL %s rsp_rdata got=%h exp=%h", name, rsp_rdata[sel], exp_data);
        end
      end
      if (k == resp + 1) begin
        total++;
        if (rsp_rdata[sel] !== exp_data) begin
          bad++;
          $display("FAIL %s rdata_hold got=%h exp=%h", name, rsp_rdata[sel], exp_data);
        end
      end
    end
    grant_rd[sel] = 1'b0;
    grant_wr[sel] = 1'b0;
    exp_rdata[sel] = exp_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      cmd_valid[i] = 1'b0; cmd_we[i] = 1'b0; cmd_addr[i] = '0; cmd_wdata[i] = '0;
      cmd_size[i] = '0; grant_rd[i] = 1'b0; grant_wr[i] = 1'b0; mem_rd[i] = '0;
      exp_rdata[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      total++;
      if ({cmd_ready[i], rsp_valid[i], rsp_we[i], rsp_err[i], req_rd[i], req_wr[i]} !== 6'b0 ||
          rsp_rdata[i] !== '0 || addr[i] !== '0 || wdata[i] !== '0 || wr_size[i] !== '0) begin
        bad++;
        $display("FAIL reset_outputs inst%0d got ready=%b req=%b%b rsp=%b exp all zero",
                 i, cmd_ready[i], req_rd[i], req_wr[i], rsp_valid[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      total++;
      if (cmd_ready[i] !== 1'b1) begin
        bad++;
        $display("FAIL reset_release_ready inst%0d got=%b exp=1", i, cmd_ready[i]);
      end
    end
  endtask

  task automatic test_store();
    fill_mem_seq();
    sched_rd = '0;
    sched_wr = 32'h1 << 3;
    run_txn(1, 1'b1, 24'h000010, {20{8'hA5}}, 3'd3, "store");
  endtask

  task automatic test_load();
    fill_mem_seq();
    mem_seq[3] = {5{32'hDEADBEEF}};
    sched_rd = 32'h1 << 2;
    sched_wr = '0;
    run_txn(1, 1'b0, 24'h000020, '0, 3'd0, "load");
  endtask

  task automatic test_timeout();
    fill_mem_seq();
    sched_rd = '0;
    sched_wr = '0;
    run_txn(1, 1'b0, 24'h000030, '0, 3'd0, "timeout_load");
    // Grant arriving after the abort must be ignored.
    sched_wr = 32'h1 << 5;
    run_txn(2, 1'b1, 24'h000034, rand_bus(), 3'd2, "timeout_store");
    sched_wr = '0;
    sched_rd = 32'h1 << TO;
    run_txn(1, 1'b0, 24'h000038, '0, 3'd0, "grant_at_timeout");
  endtask

  task automatic test_grant_faults();
    fill_mem_seq();
    sched_wr = 32'h1 << 1;
    sched_rd = (32'h1 << 2) | (32'h1 << 3) | (32'h1 << 4);
    run_txn(1, 1'b0, 24'h000040, '0, 3'd0, "held_rd_grant");
    sched_rd = (32'h1 << 1) | (32'h1 << 2);
    sched_wr = (32'h1 << 3) | (32'h1 << 4) | (32'h1 << 5);
    run_txn(0, 1'b1, 24'h000044, rand_bus(), 3'd5, "held_wr_grant");
  endtask

  task automatic test_reset_mid_op();
    cmd_valid[2] = 1'b1;
    cmd_we[2]    = 1'b1;
    cmd_addr[2]  = 24'h000050;
    cmd_wdata[2] = rand_bus();
    cmd_size[2]  = 3'd1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid[2] = 1'b0;
    total++;
    if (req_wr[2] !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid req_before got=%b exp=1", req_wr[2]);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (req_wr[2] !== 1'b0 || cmd_ready[2] !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid async_clear got req=%b ready=%b exp=0/0", req_wr[2], cmd_ready[2]);
    end
    for (int i = 0; i < N; i++) exp_rdata[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (rsp_valid[2] !== 1'b0 || req_wr[2] !== 1'b0 || cmd_ready[2] !== 1'b1) begin
        bad++;
        $display("FAIL rst_mid after c%0d got rsp=%b req=%b ready=%b exp=0/0/1",
                 k, rsp_valid[2], req_wr[2], cmd_ready[2]);
      end
    end
  endtask

  task automatic test_latency_sweep();
    for (int s = 0; s < N; s++) begin
      fill_mem_seq();
      sched_wr = '0;
      sched_rd = 32'h1 << (1 + (s % 2));
      run_txn(s, 1'b0, AW'(24'h000060 + s), '0, 3'd0, $sformatf("lat%0d", s));
    end
  endtask

  task automatic test_random();
    int sel;
    int g;
    int hold;
    logic we;
    logic [31:0] match;
    for (int t = 0; t < 40; t++) begin
      fill_mem_seq();
      sel  = $urandom_range(0, N - 1);
      we   = 1'($urandom);
      g    = $urandom_range(1, TO + 2);
      hold = $urandom_range(1, 3);
      match = '0;
      for (int k = g; k < g + hold; k++) match[k] = 1'b1;
      if (we) begin
        sched_wr = match;
        sched_rd = $urandom & 32'h3E;
      end else begin
        sched_rd = match;
        sched_wr = $urandom & 32'h3E;
      end
      run_txn(sel, we, AW'($urandom), rand_bus(), 3'($urandom), $sformatf("rand%0d", t));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench watchdog");
  end

  initial begin
    test_reset();
    test_store();
    test_load();
    test_timeout();
    test_grant_faults();
    test_reset_mid_op();
    test_latency_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
